// File: rtl/gate_timebase_sel.sv
// gate_timebase_sel: picks one of N_RANGES synchronous timebase square waves
// as the frequency-meter gate (Ctrl_CP). A range change is committed only at
// a glitch-free point. The old source's high phase is allowed to finish, and
// the new source must be low when it is taken over. Downstream logic gets a
// range-change strobe and a gate-rise strobe.
module gate_timebase_sel #(
    parameter int N_RANGES = 4,
    parameter int SEL_W    = 2,
    parameter int RST_SEL  = 0
) (
    input  logic                CP,
    input  logic                CR,
    input  logic [N_RANGES-1:0] Tick_in,
    input  logic [SEL_W-1:0]    F_sel,
    output logic                Ctrl_CP,
    output logic                Gate_rise,
    output logic                Range_chg,
    output logic                Sel_busy,
    output logic [SEL_W-1:0]    Sel_cur
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,   // Ctrl_CP follows the committed source
        DRAIN = 2'd1,   // waiting for the old source's high phase to end
        ARM   = 2'd2    // gate held low, waiting for the new source to be low
    } state_t;

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_RANGES - 1);
    localparam logic [SEL_W-1:0] RST_IDX  = SEL_W'(RST_SEL);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] tgt_q, tgt_d;
    logic             ctrl_q, ctrl_d;
    logic             rise_q, rise_d;
    logic             chg_q, chg_d;
    logic             busy_q, busy_d;

    logic [SEL_W-1:0] req;
    logic             tick_cur;
    logic             tick_tgt;

    // Out-of-range requests are clamped to the fastest timebase.
    always_comb begin
        req = F_sel;
        if (F_sel > LAST_IDX) begin
            req = LAST_IDX;
        end
    end

    // Source mux written as a compare loop, so that any N_RANGES/SEL_W pairing
    // indexes cleanly. An index outside the valid range reads as low.
    always_comb begin
        tick_cur = 1'b0;
        tick_tgt = 1'b0;
        for (int i = 0; i < N_RANGES; i++) begin
            if (sel_q == SEL_W'(i)) begin
                tick_cur = Tick_in[i];
            end
            if (tgt_q == SEL_W'(i)) begin
                tick_tgt = Tick_in[i];
            end
        end
    end

    // Next-state and output logic of the switch FSM.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        tgt_d   = tgt_q;
        ctrl_d  = ctrl_q;
        chg_d   = 1'b0;
        busy_d  = busy_q;

        case (state_q)
            RUN: begin
                ctrl_d = tick_cur;
                if (req != sel_q) begin
                    // The target is frozen here. Later F_sel moves wait for
                    // the next RUN cycle.
                    tgt_d  = req;
                    busy_d = 1'b1;
                    if (tick_cur) begin
                        state_d = DRAIN;
                    end else begin
                        ctrl_d  = 1'b0;
                        state_d = ARM;
                    end
                end
            end
            DRAIN: begin
                // Let the running gate phase complete; never truncate it.
                ctrl_d = tick_cur;
                if (!tick_cur) begin
                    ctrl_d  = 1'b0;
                    state_d = ARM;
                end
            end
            ARM: begin
                // Taking over only while the new source is low guarantees the
                // first gate phase on the new range is a whole one.
                ctrl_d = 1'b0;
                if (!tick_tgt) begin
                    sel_d   = tgt_q;
                    chg_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = RUN;
                end
            end
            default: begin
                ctrl_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = RUN;
            end
        endcase

        // Rise strobe is aligned with the registered gate it describes.
        rise_d = ctrl_d & ~ctrl_q;
    end

    // State and output registers. Reset overrides any switch in progress.
    always_ff @(posedge CP) begin
        if (CR) begin
            state_q <= RUN;
            sel_q   <= RST_IDX;
            tgt_q   <= RST_IDX;
            ctrl_q  <= 1'b0;
            rise_q  <= 1'b0;
            chg_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            tgt_q   <= tgt_d;
            ctrl_q  <= ctrl_d;
            rise_q  <= rise_d;
            chg_q   <= chg_d;
            busy_q  <= busy_d;
        end
    end

    assign Ctrl_CP   = ctrl_q;
    assign Gate_rise = rise_q;
    assign Range_chg = chg_q;
    assign Sel_busy  = busy_q;
    assign Sel_cur   = sel_q;

endmodule
